// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler
//   Picks the pending TX mailbox with the lowest identifier, starts the bit-level
//   transmitter on it, and acts on the outcome. A lost arbitration re-arbitrates
//   from scratch. A bus error retries until the mailbox hits MAX_RETRY. Host load
//   and abort requests are accepted at any time; an abort that targets the frame
//   on the wire is held until the frame ends.
// Ports
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   mb_load/mb_id_in/mb_abort     host mailbox writes and abort requests
//   bus_idle                      a new frame may start
//   tx_done/tx_arb_lost/tx_error  outcome pulses from the serializer
//   tx_start/tx_sel/tx_id         frame start command to the serializer
//   mb_pending/mb_done/mb_failed  per-mailbox status and completion pulses
//   retry_count                   error-retry count of mailbox tx_sel

// can_tx_mb: one mailbox, holding its ID, pending bit, retry counter and
// deferred-abort flag. All decisions that involve the FSM arrive already
// qualified, so this block never looks at the FSM state directly.
module can_tx_mb #(
  parameter int ID_W      = 11,
  parameter int RETRY_W   = 4,
  parameter int MAX_RETRY = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               abort,
  input  logic [ID_W-1:0]    id_in,
  input  logic               busy,     // this mailbox is in START/ACTIVE
  input  logic               ev_done,  // outcomes, priority already resolved
  input  logic               ev_err,
  input  logic               ev_arb,
  output logic [ID_W-1:0]    id,
  output logic               pending,
  output logic [RETRY_W-1:0] retry,
  output logic               done,
  output logic               failed
);
  localparam logic [RETRY_W:0] MAX_V = (RETRY_W+1)'(MAX_RETRY);

  logic             abort_flag;
  logic             abort_eff;
  logic [RETRY_W:0] retry_inc;

  // An abort arriving in the same cycle as the outcome counts as deferred too.
  assign abort_eff = abort_flag | abort;
  // One extra bit so the increment cannot wrap before the limit compare.
  assign retry_inc = {1'b0, retry} + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      id         <= '0;
      pending    <= 1'b0;
      retry      <= '0;
      abort_flag <= 1'b0;
      done       <= 1'b0;
      failed     <= 1'b0;
    end else begin
      done   <= 1'b0;
      failed <= 1'b0;
      if (busy) begin
        // Loads are ignored while the frame is in flight.
        if (abort) abort_flag <= 1'b1;
        if (ev_done) begin
          pending    <= 1'b0;
          retry      <= '0;
          done       <= 1'b1;
          abort_flag <= 1'b0;
        end else if (ev_err || ev_arb) begin
          abort_flag <= 1'b0;
          if (abort_eff || (ev_err && retry_inc >= MAX_V)) begin
            pending <= 1'b0;
            retry   <= '0;
            failed  <= 1'b1;
          end else if (ev_err) begin
            retry <= retry_inc[RETRY_W-1:0];
          end
        end
      end else begin
        abort_flag <= 1'b0;
        if (abort) begin
          // Abort beats a simultaneous load; only a live frame reports failure.
          if (pending) failed <= 1'b1;
          pending <= 1'b0;
          retry   <= '0;
        end else if (load) begin
          id      <= id_in;
          pending <= 1'b1;
          retry   <= '0;
        end
      end
    end
  end
endmodule

module can_tx_scheduler #(
  parameter int NUM_MB    = 3,
  parameter int SEL_W     = 2,
  parameter int ID_W      = 11,
  parameter int RETRY_W   = 4,
  parameter int MAX_RETRY = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MB-1:0]  mb_load,
  input  logic [ID_W-1:0]    mb_id_in,
  input  logic [NUM_MB-1:0]  mb_abort,
  input  logic               bus_idle,
  input  logic               tx_done,
  input  logic               tx_arb_lost,
  input  logic               tx_error,
  output logic               tx_start,
  output logic [SEL_W-1:0]   tx_sel,
  output logic [ID_W-1:0]    tx_id,
  output logic [NUM_MB-1:0]  mb_pending,
  output logic [NUM_MB-1:0]  mb_done,
  output logic [NUM_MB-1:0]  mb_failed,
  output logic [RETRY_W-1:0] retry_count
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_START  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [1:0]                      state;
  logic [NUM_MB-1:0][ID_W-1:0]     mb_id;
  logic [NUM_MB-1:0][RETRY_W-1:0]  mb_retry;
  logic [NUM_MB-1:0]               busy, ev_done, ev_err, ev_arb, cand;

  logic             best_found;
  logic [SEL_W-1:0] best_sel;
  logic [ID_W-1:0]  best_id;

  logic out_done, out_err, out_arb;

  // Outcome pulses only count in ACTIVE; done > error > arb_lost.
  assign out_done = (state == S_ACTIVE) && tx_done;
  assign out_err  = (state == S_ACTIVE) && !tx_done && tx_error;
  assign out_arb  = (state == S_ACTIVE) && !tx_done && !tx_error && tx_arb_lost;

  // A mailbox being aborted or rewritten this cycle sits out the arbitration,
  // otherwise we could start a frame that is being dropped or a stale ID.
  assign cand = mb_pending & ~mb_abort & ~mb_load;

  for (genvar i = 0; i < NUM_MB; i++) begin : g_mb
    logic sel_i;
    assign sel_i      = (tx_sel == SEL_W'(i));
    assign busy[i]    = (state != S_IDLE) && sel_i;
    assign ev_done[i] = out_done && sel_i;
    assign ev_err[i]  = out_err  && sel_i;
    assign ev_arb[i]  = out_arb  && sel_i;

    can_tx_mb #(
      .ID_W      (ID_W),
      .RETRY_W   (RETRY_W),
      .MAX_RETRY (MAX_RETRY)
    ) u_mb (
      .clock   (clock),
      .reset   (reset),
      .load    (mb_load[i]),
      .abort   (mb_abort[i]),
      .id_in   (mb_id_in),
      .busy    (busy[i]),
      .ev_done (ev_done[i]),
      .ev_err  (ev_err[i]),
      .ev_arb  (ev_arb[i]),
      .id      (mb_id[i]),
      .pending (mb_pending[i]),
      .retry   (mb_retry[i]),
      .done    (mb_done[i]),
      .failed  (mb_failed[i])
    );
  end

  // Lowest ID wins; strict compare in ascending index order gives ties to the
  // lowest index.
  always_comb begin
    best_found = 1'b0;
    best_sel   = '0;
    best_id    = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (cand[i] && (!best_found || mb_id[i] < best_id)) begin
        best_found = 1'b1;
        best_sel   = SEL_W'(i);
        best_id    = mb_id[i];
      end
    end
  end

  always_comb begin
    retry_count = '0;
    for (int i = 0; i < NUM_MB; i++)
      if (tx_sel == SEL_W'(i)) retry_count = mb_retry[i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      tx_start <= 1'b0;
      tx_sel   <= '0;
      tx_id    <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus_idle && best_found) begin
            tx_sel   <= best_sel;
            tx_id    <= best_id;
            tx_start <= 1'b1;  // high for exactly the START cycle
            state    <= S_START;
          end
        end
        S_START:  state <= S_ACTIVE;
        S_ACTIVE: if (tx_done || tx_error || tx_arb_lost) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end
endmodule
